conv_weight_loader: RTL

- Receiving end of the conv weight stream: captures the registered per-cycle weight words emitted by the weight cache and assembles one KERNEL_SIZE x KERNEL_SIZE kernel plus bias.
- Double-buffered: a shadow buffer fills from the stream while an active buffer is presented in parallel to the PE array under a valid/ready handshake.
- Sits between the weight cache and the conv PE array; driven by the same conv controller current_state.

---
 rtl/conv_weight_loader_pkg.sv | 32 +++
 rtl/conv_kernel_regbank.sv | 32 +++
 rtl/conv_weight_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/conv_weight_loader_pkg.sv
// rtl/conv_weight_loader_pkg.sv - shared data width, controller stage encodings and kernel geometry
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package conv_weight_loader_pkg;

    localparam int DATA_W      = `DATA_WIDTH;
    localparam int KERNEL_SIZE = 3;
    localparam int NK          = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NW          = NK + 1;
    localparam int CNT_W       = $clog2(NW + 1);

    localparam logic [2:0] STAGE_INIT    = 3'd0;
    localparam logic [2:0] STAGE_PRELOAD = 3'd1;
    localparam logic [2:0] STAGE_ROW_0   = 3'd2;
    localparam logic [2:0] STAGE_ROW_1   = 3'd3;
    localparam logic [2:0] STAGE_ROW_2   = 3'd4;
    localparam logic [2:0] STAGE_BIAS    = 3'd5;
    localparam logic [2:0] STAGE_LOAD    = 3'd6;
    localparam logic [2:0] STAGE_IDLE    = 3'd7;

    function automatic logic stage_is_capture(input logic [2:0] st);
        return (st == STAGE_ROW_0) || (st == STAGE_ROW_1) ||
               (st == STAGE_ROW_2) || (st == STAGE_BIAS);
    endfunction

    function automatic logic stage_is_clear(input logic [2:0] st);
        return (st == STAGE_PRELOAD) || (st == STAGE_LOAD);
    endfunction

endpackage

// File: rtl/conv_kernel_regbank.sv
// rtl/conv_kernel_regbank.sv - word register file with indexed write and whole-bank parallel load
module conv_kernel_regbank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10,
    parameter int IDX_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     copy_en_i,
    input  logic [DEPTH*WIDTH-1:0]   copy_data_i,
    output logic [DEPTH*WIDTH-1:0]   data_o
);

    logic [DEPTH*WIDTH-1:0] bank_q;

    // A whole-bank copy wins over a single-word write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (copy_en_i) begin
            bank_q <= copy_data_i;
        end else if (wr_en_i && (wr_idx_i < IDX_W'(DEPTH))) begin
            bank_q[int'(wr_idx_i)*WIDTH +: WIDTH] <= wr_data_i;
        end
    end

    assign data_o = bank_q;

endmodule

// File: rtl/conv_weight_loader.sv
// rtl/conv_weight_loader.sv - double-buffered kernel+bias assembler between weight cache and PE array
module conv_weight_loader
    import conv_weight_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           current_state,
    input  logic [DATA_W-1:0]    i_weight,
    input  logic                 i_kernel_ready,
    output logic [NK*DATA_W-1:0] o_kernel,
    output logic [DATA_W-1:0]    o_bias,
    output logic                 o_kernel_valid,
    output logic                 o_shadow_full,
    output logic                 o_overrun
);

    logic [2:0]           state_d1_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 cap, clr, full, free, commit, shadow_wr;
    logic [CNT_W-1:0]     shadow_idx;
    logic [NW*DATA_W-1:0] shadow_data, active_data;

    // The cache registers its word, so decisions use the state from one cycle back.
    assign cap    = stage_is_capture(state_d1_q);
    assign clr    = stage_is_clear(state_d1_q);
    assign full   = (cnt_q == CNT_W'(NW));
    assign free   = !valid_q || i_kernel_ready;
    assign commit = full && free;

    always_comb begin
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        valid_d    = valid_q;
        shadow_wr  = 1'b0;
        shadow_idx = commit ? '0 : cnt_q;
        if (clr) begin
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (commit) begin
            // Shadow drains into active this edge, so a coincident word starts the next set.
            cnt_d     = cap ? CNT_W'(1) : '0;
            shadow_wr = cap;
        end else if (cap) begin
            if (full) begin
                overrun_d = 1'b1;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
                shadow_wr = 1'b1;
            end
        end
        if (commit) begin
            valid_d = 1'b1;
        end else if (valid_q && i_kernel_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_d1_q <= STAGE_INIT;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_d1_q <= current_state;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    conv_kernel_regbank #(
        .WIDTH (DATA_W),
        .DEPTH (NW),
        .IDX_W (CNT_W)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (shadow_wr),
        .wr_idx_i    (shadow_idx),
        .wr_data_i   (i_weight),
        .copy_en_i   (1'b0),
        .copy_data_i ('0),
        .data_o      (shadow_data)
    );

    conv_kernel_regbank #(
        .WIDTH (DATA_W),
        .DEPTH (NW),
        .IDX_W (CNT_W)
    ) u_active (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_data_i   ('0),
        .copy_en_i   (commit),
        .copy_data_i (shadow_data),
        .data_o      (active_data)
    );

    assign o_kernel       = active_data[NK*DATA_W-1:0];
    assign o_bias         = active_data[NW*DATA_W-1:NK*DATA_W];
    assign o_kernel_valid = valid_q;
    assign o_shadow_full  = full;
    assign o_overrun      = overrun_q;

endmodule
